// File: rtl/truth_table_capture.sv
// Exhaustive truth-table capture: sweeps every input vector of a combinational
// unit, samples its output f, and compares the table to EXPECTED. Optional err_cnt via TT_CAPTURE_ERRCNT_EN.
module truth_table_capture #(
    parameter int                    N_IN     = 4,
    parameter int                    SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [N_IN-1:0]          vec,
    input  logic                     f,
    output logic                     busy,
    output logic                     done,
    output logic [(2**N_IN)-1:0]     tt,
    output logic                     match,
    output logic [N_IN-1:0]          first_bad
`ifdef TT_CAPTURE_ERRCNT_EN
    ,
    output logic [N_IN:0]            err_cnt
`endif
);

    localparam int TT_W  = 2**N_IN;
    localparam int CNT_W = $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  vec_q,   vec_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [TT_W-1:0]  tt_q,    tt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [TT_W-1:0]  diff_s;
    logic [N_IN-1:0]  first_bad_s;

`ifdef TT_CAPTURE_ERRCNT_EN
    function automatic logic [N_IN:0] popcount(input logic [TT_W-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < TT_W; i++) begin
            c = c + {{N_IN{1'b0}}, v[i]};
        end
        return c;
    endfunction
`endif

    // Sweep sequencer: next-state and datapath updates
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d   = '0;
                    tt_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            S_SAMPLE: begin
                tt_d[vec_q] = f;
                // Terminal vector is detected explicitly so vec never wraps
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    vec_d   = vec_q + N_IN'(1'b1);
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Lowest mismatching index; scanning downward lets the lowest hit win
    always_comb begin
        diff_s      = tt_q ^ EXPECTED;
        first_bad_s = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            first_bad_s = diff_s[i] ? N_IN'(i) : first_bad_s;
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tt        = tt_q;
    assign match     = (state_q == S_DONE) ? (diff_s == '0) : 1'b0;
    assign first_bad = (state_q == S_DONE) ? first_bad_s : '0;
`ifdef TT_CAPTURE_ERRCNT_EN
    assign err_cnt   = (state_q == S_DONE) ? popcount(diff_s) : '0;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: four instances with parity, AND and OR units
// under test, directed sweeps, ignored restart and mid-sweep reset.
module tb_truth_table_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_v;

    logic [3:0]  vec0, vec1, vec2;
    logic [1:0]  vec3;
    logic        f0, f1, f2, f3;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [15:0] tt0, tt1, tt2;
    logic [3:0]  tt3;
    logic        match0, match1, match2, match3;
    logic [3:0]  fb0, fb1, fb2;
    logic [1:0]  fb3;
`ifdef TT_CAPTURE_ERRCNT_EN
    logic [4:0]  ec0, ec1, ec2;
    logic [2:0]  ec3;
`endif

    localparam logic [15:0] EXP0 = 16'h6996;
    localparam logic [15:0] EXP1 = 16'h6997;
    localparam logic [15:0] EXP2 = 16'h0000;
    localparam logic [3:0]  EXP3 = 4'hE;

    assign f0 = ^vec0;
    assign f1 = ^vec1;
    assign f2 = &vec2;
    assign f3 = |vec3;

    always #5 clk = ~clk;

    truth_table_capture #(.N_IN(4), .SETTLE(2), .EXPECTED(EXP0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .vec(vec0), .f(f0), .busy(busy0),
        .done(done0), .tt(tt0), .match(match0), .first_bad(fb0)
`ifdef TT_CAPTURE_ERRCNT_EN
        , .err_cnt(ec0)
`endif
    );
    truth_table_capture #(.N_IN(4), .SETTLE(2), .EXPECTED(EXP1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .vec(vec1), .f(f1), .busy(busy1),
        .done(done1), .tt(tt1), .match(match1), .first_bad(fb1)
`ifdef TT_CAPTURE_ERRCNT_EN
        , .err_cnt(ec1)
`endif
    );
    truth_table_capture #(.N_IN(4), .SETTLE(2), .EXPECTED(EXP2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .vec(vec2), .f(f2), .busy(busy2),
        .done(done2), .tt(tt2), .match(match2), .first_bad(fb2)
`ifdef TT_CAPTURE_ERRCNT_EN
        , .err_cnt(ec2)
`endif
    );
    truth_table_capture #(.N_IN(2), .SETTLE(1), .EXPECTED(EXP3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .vec(vec3), .f(f3), .busy(busy3),
        .done(done3), .tt(tt3), .match(match3), .first_bad(fb3)
`ifdef TT_CAPTURE_ERRCNT_EN
        , .err_cnt(ec3)
`endif
    );

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [3:0]  fb;
        logic [4:0]  ec;
        int          lat;
        logic [3:0]  vlast;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_of(input int d);
        case (d)
            0:       return EXP0;
            1:       return EXP1;
            2:       return EXP2;
            default: return {12'h000, EXP3};
        endcase
    endfunction

    function automatic logic [15:0] model_tt(input int d);
        logic [15:0] t;
        logic [3:0]  kv;
        t = 16'h0000;
        for (int k = 0; k < ((d == 3) ? 4 : 16); k++) begin
            kv = k[3:0];
            case (d)
                0, 1:    t[k] = ^kv;
                2:       t[k] = &kv;
                default: t[k] = |kv[1:0];
            endcase
        end
        return t;
    endfunction

    function automatic logic [15:0] obs_tt(input int d);
        case (d)
            0:       return tt0;
            1:       return tt1;
            2:       return tt2;
            default: return {12'h000, tt3};
        endcase
    endfunction

    function automatic logic [3:0] obs_vec(input int d);
        case (d)
            0:       return vec0;
            1:       return vec1;
            2:       return vec2;
            default: return {2'b00, vec3};
        endcase
    endfunction

    function automatic logic [3:0] obs_fb(input int d);
        case (d)
            0:       return fb0;
            1:       return fb1;
            2:       return fb2;
            default: return {2'b00, fb3};
        endcase
    endfunction

    function automatic logic [2:0] obs_flags(input int d);  // {busy, done, match}
        case (d)
            0:       return {busy0, done0, match0};
            1:       return {busy1, done1, match1};
            2:       return {busy2, done2, match2};
            default: return {busy3, done3, match3};
        endcase
    endfunction

`ifdef TT_CAPTURE_ERRCNT_EN
    function automatic logic [4:0] obs_ec(input int d);
        case (d)
            0:       return ec0;
            1:       return ec1;
            2:       return ec2;
            default: return {2'b00, ec3};
        endcase
    endfunction
`endif

    task automatic sweep(input int d, input int restart_at);
        exp_t        e;
        logic [15:0] diff;
        logic [2:0]  fl;
        int          edges;
        e.tt    = model_tt(d);
        diff    = e.tt ^ exp_of(d);
        e.match = (diff == 16'h0000);
        e.fb    = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) e.fb = i[3:0];
        end
        e.ec    = 5'($countones(diff));
        e.lat   = (d == 3) ? (4 * 2 + 1) : (16 * 3 + 1);
        e.vlast = (d == 3) ? 4'h3 : 4'hF;
        sb.push_back(e);

        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        edges = 1;
        fl = obs_flags(d);
        check($sformatf("busy_after_start_d%0d", d), {31'd0, fl[2]}, 32'd1);
        while (obs_flags(d) [1] !== 1'b1 && edges < 200) begin
            if (edges == restart_at) start_v[d] = 1'b1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
            edges++;
        end
        fl = obs_flags(d);
        check($sformatf("done_seen_d%0d", d), {31'd0, fl[1]}, 32'd1);
        e = sb.pop_front();
        check($sformatf("latency_d%0d", d), edges, e.lat);
        check($sformatf("tt_d%0d", d), {16'd0, obs_tt(d)}, {16'd0, e.tt});
        check($sformatf("match_d%0d", d), {31'd0, fl[0]}, {31'd0, e.match});
        check($sformatf("first_bad_d%0d", d), {28'd0, obs_fb(d)}, {28'd0, e.fb});
        check($sformatf("vec_final_d%0d", d), {28'd0, obs_vec(d)}, {28'd0, e.vlast});
        check($sformatf("busy_at_done_d%0d", d), {31'd0, fl[2]}, 32'd0);
`ifdef TT_CAPTURE_ERRCNT_EN
        check($sformatf("err_cnt_d%0d", d), {27'd0, obs_ec(d)}, {27'd0, e.ec});
`endif
        @(posedge clk); #1;
        fl = obs_flags(d);
        check($sformatf("done_pulse_end_d%0d", d), {31'd0, fl[1]}, 32'd0);
        check($sformatf("match_hold_d%0d", d), {31'd0, fl[0]}, {31'd0, e.match});
        check($sformatf("tt_hold_d%0d", d), {16'd0, obs_tt(d)}, {16'd0, e.tt});
    endtask

    initial begin
        int  waited;
        logic seen_done;
        rst     = 1'b1;
        start_v = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec", {28'd0, vec0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_tt", {16'd0, tt0}, 32'd0);
        check("rst_match", {31'd0, match0}, 32'd0);
        check("rst_first_bad", {28'd0, fb0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        sweep(0, -1);
        sweep(1, -1);
        sweep(2, -1);
        sweep(3, -1);
        sweep(3, -1);
        sweep(0, 20);

        // Mid-sweep reset at vec==7
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        waited = 0;
        while (vec0 !== 4'h7 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("vec_reached_7", {28'd0, vec0}, 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_vec", {28'd0, vec0}, 32'd0);
        check("midrst_tt", {16'd0, tt0}, 32'd0);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            seen_done = seen_done | done0;
            @(posedge clk); #1;
        end
        check("midrst_no_done", {31'd0, seen_done}, 32'd0);
        check("midrst_busy_idle", {31'd0, busy0}, 32'd0);
        sweep(0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
